// File: rtl/inst_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
// The built-in ROM image lives here so bench and synthesis see the same program.
package inst_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0000;

  localparam logic [0:0] ST_BOOT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef struct packed {
    logic [31:0] code;
    logic [31:0] pc;
  } fifo_entry_t;

  // Program image: word i holds 32'h1000_0000 + i.
  function automatic logic [31:0] rom_image(input logic [31:0] idx);
    return 32'h1000_0000 + idx;
  endfunction

endpackage

// File: rtl/inst_rom.sv
// Synchronous-read instruction ROM, one cycle from addr_i/en_i to data_o.
// Contents come from the package image; an empty INIT_FILE name yields an all-NOP ROM.
module inst_rom
  import inst_fetch_pkg::*;
#(
  parameter int    ADDR_W    = 6,
  parameter string INIT_FILE = "inst_rom.coe"
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [31:0]       data_o
);

  localparam bit HAS_IMAGE = (INIT_FILE != "");

  logic [31:0] data_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      data_q <= HAS_IMAGE ? rom_image(32'(addr_i)) : NOP_INST;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: PC, one outstanding ROM read and a 2-entry {code, pc} buffer
// presented to decode over valid/ready; redirect flushes and restarts fetch.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int          ADDR_W    = 6,
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter string       INIT_FILE = "inst_rom.coe"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        inst_ready,
  output logic        inst_valid,
  output logic [31:0] inst_code,
  output logic [31:0] inst_pc,
  output logic [31:0] pc_plus4
);

  logic [0:0]             state_q, state_d;
  logic [31:0]            fetch_pc_q, fetch_pc_d;
  logic                   pending_q, pending_d;
  logic [31:0]            pending_pc_q, pending_pc_d;
  fifo_entry_t [1:0]      fifo_q, fifo_d;
  logic [1:0]             count_q, count_d;

  logic                   pop;
  logic                   issue;
  logic [1:0]             occupancy;
  logic [31:0]            rom_rdata;
  logic [31:0]            redirect_aligned;
  fifo_entry_t            captured;

  assign inst_valid = (count_q != 2'd0);
  assign inst_code  = fifo_q[0].code;
  assign inst_pc    = fifo_q[0].pc;
  assign pc_plus4   = fifo_q[0].pc + 32'd4;

  assign pop              = inst_valid & inst_ready;
  assign redirect_aligned = redirect_pc & ~32'h0000_0003;
  assign captured         = '{code: rom_rdata, pc: pending_pc_q};

  // Entries the buffer must still hold after this edge, counting the read in flight.
  assign occupancy = count_q - {1'b0, pop} + {1'b0, pending_q};
  assign issue     = !redirect_valid && ((state_q == ST_BOOT) || (occupancy < 2'd2));

  inst_rom #(
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_rom (
    .clk    (clk),
    .en_i   (issue),
    .addr_i (fetch_pc_q[ADDR_W+1:2]),
    .data_o (rom_rdata)
  );

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_d    = pending_q;
    pending_pc_d = pending_pc_q;
    fifo_d       = fifo_q;
    count_d      = count_q;

    if (redirect_valid) begin
      state_d    = ST_RUN;
      fetch_pc_d = redirect_aligned;
      pending_d  = 1'b0;
      count_d    = 2'd0;
    end else begin
      state_d = ST_RUN;

      if (pop) begin
        fifo_d[0] = fifo_q[1];
        count_d   = count_q - 2'd1;
      end

      if (pending_q) begin
        if (count_d == 2'd0) begin
          fifo_d[0] = captured;
        end else begin
          fifo_d[1] = captured;
        end
        count_d = count_d + 2'd1;
      end

      if (issue) begin
        pending_d    = 1'b1;
        pending_pc_d = fetch_pc_q;
        fetch_pc_d   = fetch_pc_q + 32'd4;
      end else begin
        pending_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_BOOT;
      fetch_pc_q   <= RESET_PC;
      pending_q    <= 1'b0;
      pending_pc_q <= RESET_PC;
      fifo_q       <= '0;
      count_q      <= 2'd0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_q    <= pending_d;
      pending_pc_q <= pending_pc_d;
      fifo_q       <= fifo_d;
      count_q      <= count_d;
    end
  end

endmodule
